// File: rtl/bufg_gt_ctrl.sv
// bufg_gt_ctrl: sequences CE / CLR_O / DIV of a divider clock buffer through safe divide-code changes.
// Define BUFG_GT_CTRL_RECFG_CNT_EN to enable the completed-reconfiguration counter on RECFG_CNT.
module bufg_gt_ctrl #(
  parameter logic [2:0] INIT_DIV      = 3'd0,
  parameter int         CE_OFF_CYCLES = 4,
  parameter int         CLR_CYCLES    = 2,
  parameter int         SETTLE_CYCLES = 8
) (
  input  logic       I,
  input  logic       CLR,
  input  logic       REQ_VLD,
  input  logic [2:0] REQ_DIV,
  output logic       REQ_RDY,
  output logic       CE,
  output logic       CLR_O,
  output logic [2:0] DIV,
  output logic       LOCKED,
  output logic [7:0] RECFG_CNT
);

  // Down-counter reload value: a state lasting n edges loads n-1; 0 behaves as 1.
  function automatic logic [3:0] load_val(input int n);
    if (n <= 1)
      return 4'd0;
    else if (n >= 15)
      return 4'd14;
    else
      return 4'(n - 1);
  endfunction

  localparam logic [3:0] GATE_LD   = load_val(CE_OFF_CYCLES);
  localparam logic [3:0] CLEAR_LD  = load_val(CLR_CYCLES);
  localparam logic [3:0] SETTLE_LD = load_val(SETTLE_CYCLES);

  typedef enum logic [2:0] {SYNC, CLEAR, SETTLE, IDLE, GATE} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [2:0] div_hold_reg;
  logic [1:0] sync_reg;
  logic       release_pulse;

  // Reset-release synchronizer: the pattern 2'b10 appears exactly on the 2nd edge after CLR falls.
  always_ff @(posedge I or posedge CLR) begin
    if (CLR)
      sync_reg <= 2'b11;
    else
      sync_reg <= {sync_reg[0], 1'b0};
  end

  assign release_pulse = sync_reg[1] & ~sync_reg[0];

  always_ff @(posedge I or posedge CLR) begin
    if (CLR) begin
      state_reg    <= SYNC;
      cnt_reg      <= 4'd0;
      div_hold_reg <= INIT_DIV;
      CE           <= 1'b0;
      CLR_O        <= 1'b1;
      DIV          <= INIT_DIV;
      REQ_RDY      <= 1'b0;
      LOCKED       <= 1'b0;
    end else begin
      case (state_reg)
        SYNC: begin
          if (release_pulse) begin
            state_reg <= CLEAR;
            cnt_reg   <= CLEAR_LD;
          end
        end
        CLEAR: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= SETTLE;
            cnt_reg   <= SETTLE_LD;
            CLR_O     <= 1'b0;
            CE        <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        SETTLE: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= IDLE;
            REQ_RDY   <= 1'b1;
            LOCKED    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        IDLE: begin
          // A request for the current code is accepted but needs no reconfiguration.
          if (REQ_VLD && (REQ_DIV != DIV)) begin
            state_reg    <= GATE;
            cnt_reg      <= GATE_LD;
            div_hold_reg <= REQ_DIV;
            CE           <= 1'b0;
            REQ_RDY      <= 1'b0;
            LOCKED       <= 1'b0;
          end
        end
        GATE: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= CLEAR;
            cnt_reg   <= CLEAR_LD;
            DIV       <= div_hold_reg;
            CLR_O     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= SYNC;
          cnt_reg   <= 4'd0;
          CE        <= 1'b0;
          CLR_O     <= 1'b1;
          REQ_RDY   <= 1'b0;
          LOCKED    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUFG_GT_CTRL_RECFG_CNT_EN
  logic       gated_reg;
  logic [7:0] recfg_cnt_reg;

  // Only a SETTLE entered via GATE counts; the post-reset settle does not.
  always_ff @(posedge I or posedge CLR) begin
    if (CLR) begin
      gated_reg     <= 1'b0;
      recfg_cnt_reg <= 8'd0;
    end else if (state_reg == GATE) begin
      gated_reg <= 1'b1;
    end else if ((state_reg == SETTLE) && (cnt_reg == 4'd0)) begin
      gated_reg <= 1'b0;
      if (gated_reg)
        recfg_cnt_reg <= recfg_cnt_reg + 8'd1;
    end
  end

  assign RECFG_CNT = recfg_cnt_reg;
`else
  assign RECFG_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_bufg_gt_ctrl.sv
// Testbench for bufg_gt_ctrl: vector table for reset release / reconfig / same-code request,
// plus sequences for mid-sequence CLR and 256 back-to-back requests.
module tb_bufg_gt_ctrl;

`ifdef BUFG_GT_CTRL_RECFG_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       I;
  logic       CLR;
  logic       REQ_VLD;
  logic [2:0] REQ_DIV;
  logic       REQ_RDY;
  logic       CE;
  logic       CLR_O;
  logic [2:0] DIV;
  logic       LOCKED;
  logic [7:0] RECFG_CNT;

  int checks   = 0;
  int failures = 0;

  bufg_gt_ctrl dut (
    .I        (I),
    .CLR      (CLR),
    .REQ_VLD  (REQ_VLD),
    .REQ_DIV  (REQ_DIV),
    .REQ_RDY  (REQ_RDY),
    .CE       (CE),
    .CLR_O    (CLR_O),
    .DIV      (DIV),
    .LOCKED   (LOCKED),
    .RECFG_CNT(RECFG_CNT)
  );

  initial I = 1'b0;
  always #5 I = ~I;

  typedef struct {
    logic       vld;
    logic [2:0] rdiv;
    logic       ce;
    logic       clro;
    logic [2:0] dv;
    logic       rdy;
    logic       lk;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vld, input logic [2:0] rdiv, input logic ce,
                              input logic clro, input logic [2:0] dv, input logic rdy,
                              input logic lk, input logic [7:0] cnt);
    vec_t v;
    v.vld = vld; v.rdiv = rdiv; v.ce = ce; v.clro = clro;
    v.dv = dv; v.rdy = rdy; v.lk = lk; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge I);
    #1;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (REQ_RDY !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check(name, {7'd0, REQ_RDY}, 8'd1);
  endtask

  task automatic do_req(input logic [2:0] d);
    wait_rdy("req_rdy_timeout");
    REQ_VLD = 1'b1;
    REQ_DIV = d;
    step();
    REQ_VLD = 1'b0;
  endtask

  // CE and CLR_O must never be high together.
  always @(negedge I) begin
    if (CLR === 1'b0) begin
      checks++;
      if (CE === 1'b1 && CLR_O === 1'b1) begin
        failures++;
        $display("FAIL ce_clro_overlap got=CE1,CLR_O1 exp=not_both");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c1;
    int e;
    c1 = CNT_ON ? 8'd1 : 8'd0;

    // Edge 1 is the first posedge after CLR falls; request accepted at edge 13 (n).
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));                 // e1 SYNC
    for (int k = 2; k <= 3; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));  // CLEAR
    for (int k = 4; k <= 11; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0)); // SETTLE
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));                 // e12 IDLE
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));                 // e13 accept -> GATE
    for (int k = 14; k <= 16; k++) tbl.push_back(mk(logic'(k % 2), 5, 0, 0, 0, 0, 0, 0)); // GATE
    for (int k = 17; k <= 18; k++) tbl.push_back(mk(logic'(k % 2), 5, 0, 1, 3, 0, 0, 0)); // CLEAR
    for (int k = 19; k <= 26; k++) tbl.push_back(mk(logic'(k % 2), 5, 1, 0, 3, 0, 0, 0)); // SETTLE
    tbl.push_back(mk(0, 0, 1, 0, 3, 1, 1, c1));                // e27 IDLE, counted
    tbl.push_back(mk(1, 3, 1, 0, 3, 1, 1, c1));                // same-code request consumed
    tbl.push_back(mk(0, 0, 1, 0, 3, 1, 1, c1));

    CLR = 1'b1;
    REQ_VLD = 1'b0;
    REQ_DIV = 3'd0;
    #2;
    check("rst_ce", {7'd0, CE}, 8'd0);
    check("rst_clro", {7'd0, CLR_O}, 8'd1);
    check("rst_div", {5'd0, DIV}, 8'd0);
    check("rst_rdy", {7'd0, REQ_RDY}, 8'd0);
    check("rst_locked", {7'd0, LOCKED}, 8'd0);
    check("rst_cnt", RECFG_CNT, 8'd0);
    step();
    step();
    CLR = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      REQ_VLD = tbl[i].vld;
      REQ_DIV = tbl[i].rdiv;
      step();
      $display("vec e%0d vld=%0b rdiv=%0d ce=%0b clro=%0b div=%0d rdy=%0b lk=%0b cnt=%0d",
               i + 1, tbl[i].vld, tbl[i].rdiv, CE, CLR_O, DIV, REQ_RDY, LOCKED, RECFG_CNT);
      check($sformatf("e%0d_ce", i + 1), {7'd0, CE}, {7'd0, tbl[i].ce});
      check($sformatf("e%0d_clro", i + 1), {7'd0, CLR_O}, {7'd0, tbl[i].clro});
      check($sformatf("e%0d_div", i + 1), {5'd0, DIV}, {5'd0, tbl[i].dv});
      check($sformatf("e%0d_rdy", i + 1), {7'd0, REQ_RDY}, {7'd0, tbl[i].rdy});
      check($sformatf("e%0d_locked", i + 1), {7'd0, LOCKED}, {7'd0, tbl[i].lk});
      check($sformatf("e%0d_cnt", i + 1), RECFG_CNT, tbl[i].cnt);
    end
    REQ_VLD = 1'b0;

    // CLR pulse in CLEAR of a 0->3 reconfiguration: abort and replay reset timing.
    do_req(3'd0);
    wait_rdy("abort_pre_idle");
    do_req(3'd3);
    for (int k = 0; k < 5; k++) step();
    check("abort_pre_div", {5'd0, DIV}, 8'd3);
    check("abort_pre_clro", {7'd0, CLR_O}, 8'd1);
    CLR = 1'b1;
    #1;
    check("abort_div", {5'd0, DIV}, 8'd0);
    check("abort_ce", {7'd0, CE}, 8'd0);
    check("abort_clro", {7'd0, CLR_O}, 8'd1);
    check("abort_locked", {7'd0, LOCKED}, 8'd0);
    check("abort_cnt", RECFG_CNT, 8'd0);
    #1;
    CLR = 1'b0;
    $display("seq abort: CLR pulsed at n+5");
    e = 0;
    while (CLR_O !== 1'b0 && e < 30) begin
      step();
      e++;
    end
    check("abort_clro_fall_edge", 8'(e), 8'd4);
    check("abort_ce_after", {7'd0, CE}, 8'd1);
    while (LOCKED !== 1'b1 && e < 30) begin
      step();
      e++;
    end
    check("abort_locked_edge", 8'(e), 8'd12);
    check("abort_div_after", {5'd0, DIV}, 8'd0);
    check("abort_cnt_after", RECFG_CNT, 8'd0);

    // 256 back-to-back alternating requests: counter wraps.
    for (int i = 0; i < 256; i++) begin
      do_req((i % 2) ? 3'd5 : 3'd3);
      if (i == 127) begin
        wait_rdy("wrap_mid_idle");
        check("wrap_cnt_128", RECFG_CNT, CNT_ON ? 8'd128 : 8'd0);
        check("wrap_div_128", {5'd0, DIV}, 8'd5);
      end
    end
    wait_rdy("wrap_end_idle");
    $display("seq wrap: 256 requests done cnt=%0d div=%0d", RECFG_CNT, DIV);
    check("wrap_cnt_256", RECFG_CNT, 8'd0);
    check("wrap_div_256", {5'd0, DIV}, 8'd5);
    check("wrap_locked", {7'd0, LOCKED}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bufg_gt_ctrl.md
BUFG_GT_CTRL -- requirements
Module: bufg_gt_ctrl

Interface
REQ-001 SHALL have parameter INIT_DIV, default 3'd0: DIV value driven out of reset.
REQ-002 SHALL have parameter CE_OFF_CYCLES, default 4: I edges with CE low before DIV changes; legal 1..15, 0 treated as 1.
REQ-003 SHALL have parameter CLR_CYCLES, default 2: I edges CLR_O is held high; legal 1..15, 0 treated as 1.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8: I edges after CE re-enable before LOCKED rises; legal 1..15, 0 treated as 1.
REQ-005 SHALL have port I, input, 1 bit: source clock, the same net that feeds the divider buffer; all logic on posedge I.
REQ-006 SHALL have port CLR, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port REQ_VLD, input, 1 bit: divide-change request valid.
REQ-008 SHALL have port REQ_DIV, input, 3 bits: requested divide code.
REQ-009 SHALL have port REQ_RDY, output, 1 bit: request accepted when REQ_VLD and REQ_RDY are both high at posedge I.
REQ-010 SHALL have port CE, output, 1 bit: divider buffer clock enable.
REQ-011 SHALL have port CLR_O, output, 1 bit: divider buffer clear.
REQ-012 SHALL have port DIV, output, 3 bits: divide code to the divider buffer.
REQ-013 SHALL have port LOCKED, output, 1 bit: divided clock stable at DIV.
REQ-014 SHALL have port RECFG_CNT, output, 8 bits: count of completed reconfigurations.

Function
REQ-015 SHALL implement FSM states SYNC, CLEAR, SETTLE, IDLE, GATE, with a 4-bit down-counter shared by all timed states.
REQ-016 SHALL drive REQ_RDY=1 and LOCKED=1 only in IDLE; both SHALL be 0 in every other state.
REQ-017 IDLE, accepted request with REQ_DIV != DIV: next state GATE, CE=0 from that edge, REQ_DIV captured.
REQ-018 IDLE, accepted request with REQ_DIV == DIV: SHALL be consumed with no state change, no CE glitch and no RECFG_CNT increment.
REQ-019 GATE SHALL last CE_OFF_CYCLES edges, then enter CLEAR, loading DIV with the captured code and setting CLR_O=1 on the same edge.
REQ-020 CLEAR SHALL last CLR_CYCLES edges, then enter SETTLE with CLR_O=0 and CE=1 on the same edge.
REQ-021 SETTLE SHALL last SETTLE_CYCLES edges, then enter IDLE with LOCKED=1.
REQ-022 DIV SHALL change only on the GATE->CLEAR edge; CE and CLR_O SHALL never be high together.
REQ-023 REQ_VLD outside IDLE SHALL be ignored; the requester holds it until REQ_RDY.

Reset
REQ-024 CLR high SHALL immediately force state SYNC, CE=0, CLR_O=1, DIV=INIT_DIV, REQ_RDY=0, LOCKED=0, RECFG_CNT=0.
REQ-025 Deassertion SHALL pass through an internal 2-flop synchronizer on I; SYNC exits to CLEAR on the 2nd posedge I after CLR falls, CLR_O held at 1 throughout.
REQ-026 CLR mid-sequence SHALL abort; the captured request SHALL be dropped and DIV SHALL return to INIT_DIV.

Configuration
REQ-027 With BUFG_GT_CTRL_RECFG_CNT_EN defined, RECFG_CNT SHALL increment on each SETTLE->IDLE edge that follows a GATE, wrapping 255->0; the post-reset sequence SHALL not count.
REQ-028 Without BUFG_GT_CTRL_RECFG_CNT_EN, RECFG_CNT SHALL be tied to 8'd0 with no counter logic.

Verification
REQ-029 Reset release, defaults: CLR falls; edge 2 -> CLEAR; CLR_O=0, CE=1 after edge 4; LOCKED=1 after edge 12; DIV=0.
REQ-030 Request REQ_DIV=3 accepted at edge n: CE=0 after n; DIV=3, CLR_O=1 after n+4; CLR_O=0, CE=1 after n+6; LOCKED=1 after n+14; RECFG_CNT=1 (macro on).
REQ-031 Request REQ_DIV=0 with DIV=0: REQ_RDY stays 1; CE, DIV, LOCKED unchanged; RECFG_CNT unchanged.
REQ-032 CLR pulsed at n+5 during the REQ-030 sequence: DIV=0, CE=0, CLR_O=1 immediately; the REQ-029 timing repeats; RECFG_CNT=0.
REQ-033 256 back-to-back alternating 3/5 requests, macro on: RECFG_CNT wraps to 0; macro off: RECFG_CNT constant 0.
REQ-034 REQ_VLD toggled during GATE/CLEAR/SETTLE: no extra acceptance; DIV changes once per accepted request.
